bram_load_arbiter: RTL and testbench

- Shares one halfword packer among three streaming load sources: data (0), weight (1) and bias (2).
- Each source is arbitrated per burst, packs BURST_LEN 16-bit halfwords into one 16*BURST_LEN-bit line, and writes that line into its own BRAM (d_bram, w_bram, b_bram) at a self-generated, auto-incrementing address.
- Sits between the okClk-side pipe-in endpoints and the BRAM write ports.
- Replaces the ad hoc per-pipe write-counter logic and gives every BRAM the same packing order and full protection.

---
 rtl/bram_load_arbiter_if.sv | 35 +++
 rtl/bram_load_arbiter.sv | 160 ++++++++++++++++
 tb/tb_bram_load_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_load_arbiter_if.sv
// Stream-side and BRAM-side signals of the three-source BRAM line loader.
// The arbiter takes the slave modport; the pipe/BRAM side takes the master modport.
interface bram_load_arbiter_if #(
    parameter int BURST_LEN = 8,
    parameter int D_AW      = 10,
    parameter int W_AW      = 13,
    parameter int B_AW      = 10
);
    logic [2:0]               src_valid;
    logic [47:0]              src_data;
    logic [2:0]               src_ready;
    logic [16*BURST_LEN-1:0]  line_data;
    logic                     d_we;
    logic                     w_we;
    logic                     b_we;
    logic [D_AW-1:0]          d_addr;
    logic [W_AW-1:0]          w_addr;
    logic [B_AW-1:0]          b_addr;
    logic                     d_full;
    logic                     w_full;
    logic                     b_full;
    logic                     busy;

    modport master (
        output src_valid, src_data,
        input  src_ready, line_data, d_we, w_we, b_we,
               d_addr, w_addr, b_addr, d_full, w_full, b_full, busy
    );

    modport slave (
        input  src_valid, src_data,
        output src_ready, line_data, d_we, w_we, b_we,
               d_addr, w_addr, b_addr, d_full, w_full, b_full, busy
    );
endinterface

// File: rtl/bram_load_arbiter.sv
// Round-robin burst arbiter that packs BURST_LEN halfwords from one of three
// sources into a line and writes it to that source's BRAM at an auto address.
module bram_load_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int D_AW      = 10,
    parameter int W_AW      = 13,
    parameter int B_AW      = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    bram_load_arbiter_if.slave bus
);
    localparam int LINE_W = 16 * BURST_LEN;
    localparam int CNT_W  = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        grant_oh;
    logic [1:0]        grant_idx;
    logic [1:0]        last_grant;
    logic [CNT_W-1:0]  cnt;
    logic [LINE_W-1:0] line_q;
    logic [2:0]        we_q;
    logic [2:0]        full_q;
    logic [D_AW-1:0]   d_addr_q;
    logic [W_AW-1:0]   w_addr_q;
    logic [B_AW-1:0]   b_addr_q;

    logic [2:0]        wrap_now;
    logic [2:0]        eligible;
    logic [2:0]        pick_oh;
    logic [1:0]        pick_idx;
    logic              found;
    logic              accept;
    logic [15:0]       hw;
    int                rr_k;

    // The write strobe trails WRITE by one cycle, so a line landing on the last
    // address must already count as full for the grant made in that same cycle.
    assign wrap_now = {we_q[2] && (b_addr_q == '1),
                       we_q[1] && (w_addr_q == '1),
                       we_q[0] && (d_addr_q == '1)};
    assign eligible = bus.src_valid & ~(full_q | wrap_now);

    always_comb begin
        pick_oh  = 3'b000;
        pick_idx = 2'd0;
        found    = 1'b0;
        rr_k     = 0;
        for (int i = 1; i <= 3; i++) begin
            rr_k = (int'(last_grant) + i) % 3;
            if (!found && eligible[rr_k]) begin
                found          = 1'b1;
                pick_oh[rr_k]  = 1'b1;
                pick_idx       = rr_k[1:0];
            end
        end
    end

    always_comb begin
        hw = bus.src_data[15:0];
        case (grant_idx)
            2'd1:    hw = bus.src_data[31:16];
            2'd2:    hw = bus.src_data[47:32];
            default: hw = bus.src_data[15:0];
        endcase
    end

    assign accept = (state == FILL) && (|(bus.src_valid & grant_oh));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_oh   <= 3'b000;
            grant_idx  <= 2'd0;
            last_grant <= 2'd2;
            cnt        <= '0;
            line_q     <= '0;
            we_q       <= 3'b000;
            full_q     <= 3'b000;
            d_addr_q   <= '0;
            w_addr_q   <= '0;
            b_addr_q   <= '0;
        end else if (clr) begin
            state      <= IDLE;
            grant_oh   <= 3'b000;
            grant_idx  <= 2'd0;
            last_grant <= 2'd2;
            cnt        <= '0;
            line_q     <= '0;
            we_q       <= 3'b000;
            full_q     <= 3'b000;
            d_addr_q   <= '0;
            w_addr_q   <= '0;
            b_addr_q   <= '0;
        end else begin
            we_q <= 3'b000;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_oh  <= pick_oh;
                        grant_idx <= pick_idx;
                        cnt       <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        line_q <= {hw, line_q[LINE_W-1:16]};
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    we_q       <= grant_oh;
                    last_grant <= grant_idx;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Address post-increments on the edge that completes the write.
            if (we_q[0]) begin
                d_addr_q <= d_addr_q + 1'b1;
                if (wrap_now[0]) full_q[0] <= 1'b1;
            end
            if (we_q[1]) begin
                w_addr_q <= w_addr_q + 1'b1;
                if (wrap_now[1]) full_q[1] <= 1'b1;
            end
            if (we_q[2]) begin
                b_addr_q <= b_addr_q + 1'b1;
                if (wrap_now[2]) full_q[2] <= 1'b1;
            end
        end
    end

    assign bus.src_ready = (state == FILL) ? grant_oh : 3'b000;
    assign bus.line_data = line_q;
    assign bus.d_we      = we_q[0];
    assign bus.w_we      = we_q[1];
    assign bus.b_we      = we_q[2];
    assign bus.d_addr    = d_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.d_full    = full_q[0];
    assign bus.w_full    = full_q[1];
    assign bus.b_full    = full_q[2];
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_bram_load_arbiter.sv
// Bench for bram_load_arbiter: burst-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bram_load_arbiter;
    localparam int BL = 8;
    localparam int DA = 2;
    localparam int WA = 4;
    localparam int BA = 3;

    logic clk;
    logic rst_n;
    logic clr;

    bram_load_arbiter_if #(.BURST_LEN(BL), .D_AW(DA), .W_AW(WA), .B_AW(BA)) bus ();

    bram_load_arbiter #(.BURST_LEN(BL), .D_AW(DA), .W_AW(WA), .B_AW(BA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (burst-level) ----------------
    int           m_owner;     // source holding the current burst, -1 when none
    bit           m_done;      // burst complete, line waiting to be written
    int           m_we;        // source whose write strobe is visible now, -1 none
    int           m_last;
    int           m_addr[3];
    logic [2:0]   m_full;
    logic [15:0]  m_q[$];
    logic [127:0] m_line;

    function automatic int amax(input int k);
        case (k)
            0:       return (1 << DA) - 1;
            1:       return (1 << WA) - 1;
            default: return (1 << BA) - 1;
        endcase
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_done  = 1'b0;
        m_we    = -1;
        m_last  = 2;
        for (int k = 0; k < 3; k++) m_addr[k] = 0;
        m_full  = 3'b000;
        m_q.delete();
        m_line  = '0;
    endtask

    task automatic m_step();
        int nxt_we;
        if (clr) begin
            m_reset();
            return;
        end
        if (m_we >= 0) begin
            if (m_addr[m_we] == amax(m_we)) begin
                m_addr[m_we] = 0;
                m_full[m_we] = 1'b1;
            end else begin
                m_addr[m_we] = m_addr[m_we] + 1;
            end
        end
        nxt_we = -1;
        if (m_owner < 0) begin
            for (int i = 1; i <= 3; i++) begin
                automatic int k = (m_last + i) % 3;
                if (bus.src_valid[k] && !m_full[k]) begin
                    m_owner = k;
                    m_q.delete();
                    break;
                end
            end
        end else if (m_done) begin
            nxt_we  = m_owner;
            m_last  = m_owner;
            m_owner = -1;
            m_done  = 1'b0;
        end else if (bus.src_valid[m_owner]) begin
            m_q.push_back(bus.src_data[16*m_owner +: 16]);
            if (m_q.size() == BL) begin
                m_done = 1'b1;
                for (int i = 0; i < BL; i++) m_line[16*i +: 16] = m_q[i];
            end
        end
        m_we = nxt_we;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // ---------------- per-cycle compare and write log ----------------
    int           we_src[$];
    int           we_cyc[$];
    int           we_addr[$];
    logic [127:0] we_line[$];

    task automatic clear_log();
        we_src.delete();
        we_cyc.delete();
        we_addr.delete();
        we_line.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                automatic logic [2:0] exp_ready = (m_owner >= 0 && !m_done) ? 3'(1 << m_owner) : 3'b000;
                automatic logic [2:0] exp_we    = (m_we >= 0) ? 3'(1 << m_we) : 3'b000;
                chk("src_ready", bus.src_ready, exp_ready);
                chk("we", {bus.b_we, bus.w_we, bus.d_we}, exp_we);
                chk("busy", bus.busy, m_owner >= 0);
                chk("d_addr", bus.d_addr, m_addr[0]);
                chk("w_addr", bus.w_addr, m_addr[1]);
                chk("b_addr", bus.b_addr, m_addr[2]);
                chk("full", {bus.b_full, bus.w_full, bus.d_full}, m_full);
                if (exp_we != 3'b000) chk("line_data", bus.line_data, m_line);
                if (bus.d_we || bus.w_we || bus.b_we) begin
                    we_src.push_back(bus.w_we ? 1 : (bus.b_we ? 2 : 0));
                    we_cyc.push_back(cyc);
                    we_addr.push_back(bus.w_we ? int'(bus.w_addr) : (bus.b_we ? int'(bus.b_addr) : int'(bus.d_addr)));
                    we_line.push_back(bus.line_data);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic feed(input int src, input int n, input logic [15:0] base,
                        input int gap_after, input int gap_len, input int poke,
                        output int first);
        int i     = 0;
        int gap   = 0;
        int guard = 0;
        first = -1;
        while (i < n) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                chk("feed_timeout", 1'b1, 1'b0);
                break;
            end
            if (gap_after >= 0 && i == gap_after && gap < gap_len) begin
                bus.src_valid[src] = 1'b0;
                if (poke >= 0) bus.src_valid[poke] = 1'b1;
                chk("gap_ready", bus.src_ready, 3'(1 << src));
                gap++;
            end else begin
                if (poke >= 0) bus.src_valid[poke] = 1'b0;
                bus.src_valid[src] = 1'b1;
                bus.src_data[16*src +: 16] = base + 16'(i);
                if (bus.src_ready[src]) begin
                    if (i == 0) first = cyc;
                    i++;
                end
            end
        end
        @(negedge clk);
        bus.src_valid[src] = 1'b0;
    endtask

    task automatic wait_we(input int n, input int budget);
        int t = 0;
        while (we_src.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("wait_we", we_src.size() >= n, 1'b1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int first;
        int n;
        bit saw;
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.src_valid = 3'b000;
        bus.src_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ready", bus.src_ready, 3'b000);
        chk("rst_daddr", bus.d_addr, 0);
        chk("rst_line", bus.line_data, 128'h0);
        chk("rst_full", {bus.b_full, bus.w_full, bus.d_full}, 3'b000);
        rst_n = 1'b1;

        // single source burst
        clear_log();
        feed(0, 8, 16'h0001, -1, 0, -1, first);
        wait_we(1, 20);
        if (we_src.size() >= 1) begin
            chk("t1_latency", we_cyc[0] - first, 9);
            chk("t1_src", we_src[0], 0);
            chk("t1_addr", we_addr[0], 0);
            chk("t1_line", we_line[0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        end
        @(negedge clk);
        chk("t1_addr_after", bus.d_addr, 1);

        // round robin with all sources streaming
        do_clr();
        clear_log();
        bus.src_valid = 3'b111;
        for (int t = 0; t < 80 && we_src.size() < 4; t++) begin
            @(negedge clk);
            bus.src_data = 48'({$urandom, $urandom});
        end
        bus.src_valid = 3'b000;
        chk("rr_count", we_src.size() >= 4, 1'b1);
        if (we_src.size() >= 4) begin
            chk("rr_order", {8'(we_src[0]), 8'(we_src[1]), 8'(we_src[2]), 8'(we_src[3])}, 32'h00010200);
            chk("rr_period1", we_cyc[1] - we_cyc[0], 10);
            chk("rr_period2", we_cyc[2] - we_cyc[1], 10);
            chk("rr_period3", we_cyc[3] - we_cyc[2], 10);
            chk("rr_d_second_addr", we_addr[3], 1);
        end
        chk("rr_w_addr", bus.w_addr, 1);
        chk("rr_b_addr", bus.b_addr, 1);

        // valid gap on the weight source
        do_clr();
        clear_log();
        feed(1, 8, 16'h0100, 3, 5, 0, first);
        wait_we(1, 30);
        if (we_src.size() >= 1) begin
            chk("gap_latency", we_cyc[0] - first, 14);
            chk("gap_src", we_src[0], 1);
            chk("gap_addr", we_addr[0], 0);
            chk("gap_line", we_line[0], 128'h0107_0106_0105_0104_0103_0102_0101_0100);
        end

        // data BRAM fills up and wraps
        do_clr();
        clear_log();
        for (int l = 0; l < 4; l++) begin
            feed(0, 8, 16'h1000 + 16'(l * 16), -1, 0, -1, first);
            wait_we(l + 1, 20);
        end
        if (we_addr.size() >= 4) chk("full_4th_addr", we_addr[3], 3);
        @(negedge clk);
        chk("full_flag", bus.d_full, 1'b1);
        chk("full_wrap", bus.d_addr, 0);
        clear_log();
        saw = 1'b0;
        bus.src_valid = 3'b011;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            bus.src_data = 48'({$urandom, $urandom});
            if (bus.src_ready[0]) saw = 1'b1;
        end
        bus.src_valid = 3'b000;
        chk("full_blocked", saw, 1'b0);
        n = 0;
        foreach (we_src[j]) if (we_src[j] == 1) n++;
        chk("full_w_served", n > 0, 1'b1);

        // clear in the middle of a burst
        do_clr();
        clear_log();
        feed(1, 4, 16'h0200, -1, 0, -1, first);
        do_clr();
        chk("clr_busy", bus.busy, 1'b0);
        chk("clr_w_addr", bus.w_addr, 0);
        repeat (12) @(negedge clk);
        chk("clr_no_write", we_src.size(), 0);
        feed(1, 8, 16'h0300, -1, 0, -1, first);
        wait_we(1, 20);
        if (we_src.size() >= 1) begin
            chk("clr_fresh_src", we_src[0], 1);
            chk("clr_fresh_addr", we_addr[0], 0);
            chk("clr_fresh_line", we_line[0], 128'h0307_0306_0305_0304_0303_0302_0301_0300);
        end

        // asynchronous reset while a line is being written
        do_clr();
        clear_log();
        feed(0, 8, 16'h0400, -1, 0, -1, first);
        wait_we(1, 20);
        feed(0, 8, 16'h0500, -1, 0, -1, first);
        chk("ar_busy_pre", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", bus.src_ready, 3'b000);
        chk("ar_we", {bus.b_we, bus.w_we, bus.d_we}, 3'b000);
        chk("ar_busy", bus.busy, 1'b0);
        chk("ar_d_addr", bus.d_addr, 0);
        chk("ar_line", bus.line_data, 128'h0);
        n = we_src.size();
        for (int t = 0; t < 3; t++) begin
            @(posedge clk);
            #1 chk("ar_we_held", bus.d_we, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("ar_no_late_we", we_src.size(), n);

        // randomized traffic with occasional clears
        do_clr();
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            bus.src_valid = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            bus.src_data  = 48'({$urandom, $urandom});
            clr           = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        bus.src_valid = 3'b000;
        clr           = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
